// File: rtl/ex_stage_md.sv
// MIPS execute stage: operand forwarding, single-cycle ALU, HI/LO and an iterative mult/div unit.
// Define EX_MD_DIV_EN to build the restoring divider; without it div/divu are no-ops on HI/LO.
module ex_stage_md #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_ex_valid,
    input  logic [31:0]       id_ex_instr,
    input  logic [1:0]        id_ex_alu_op,
    input  logic              id_ex_alu_src,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [DATA_W-1:0] id_ex_imm_value,
    input  logic [DATA_W-1:0] ex_mem_alu_result,
    input  logic [DATA_W-1:0] mem_wb_write_back_result,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    output logic [DATA_W-1:0] alu_in2_out,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic              ex_stall,
    output logic              md_busy
);
    localparam int unsigned W = DATA_W;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     hi_q, lo_q;
    logic [W:0]       md_acc_q;
    logic [W-1:0]     md_lo_q, md_b_q;
    logic             md_neg_q;
`ifdef EX_MD_DIV_EN
    logic             md_is_div_q, md_neg_rem_q, md_div0_q;
    logic             is_div;
    logic [W:0]       div_shift, div_trial;
`endif

    logic [W-1:0]   op_a, fwd_b, op_b;
    logic [5:0]     funct;
    logic           is_rtype, hilo_op, fire, md_start;
    logic           is_mult, is_mthi, is_mtlo;
    logic           md_signed, sign_a, sign_b;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mul_sum, step_acc_d;
    logic [W-1:0]   step_lo_d;
    logic [2*W-1:0] prod_mag, prod_fin;
    logic [W-1:0]   fin_hi, fin_lo;
    logic           unused_instr;

    assign unused_instr = ^id_ex_instr[31:6];

    // Forwarding muxes; 00 and 11 both take the register file value
    always_comb begin
        op_a = reg1;
        case (forward_a)
            2'b01:   op_a = mem_wb_write_back_result;
            2'b10:   op_a = ex_mem_alu_result;
            default: op_a = reg1;
        endcase
        fwd_b = reg2;
        case (forward_b)
            2'b01:   fwd_b = mem_wb_write_back_result;
            2'b10:   fwd_b = ex_mem_alu_result;
            default: fwd_b = reg2;
        endcase
        op_b = id_ex_alu_src ? id_ex_imm_value : fwd_b;
    end

    assign alu_in2_out = fwd_b;
    assign funct       = id_ex_instr[5:0];
    assign is_rtype    = (id_ex_alu_op == 2'b10);
    assign hilo_op     = id_ex_valid & is_rtype &
                         ((funct[5:2] == 4'b0100) | (funct[5:2] == 4'b0110));
    assign md_busy     = (state_q == MD_BUSY);
    assign ex_stall    = hilo_op & md_busy;
    assign fire        = id_ex_valid & ~ex_stall;
    assign is_mult     = is_rtype & ((funct == 6'h18) | (funct == 6'h19));
    assign is_mthi     = is_rtype & (funct == 6'h11);
    assign is_mtlo     = is_rtype & (funct == 6'h13);
`ifdef EX_MD_DIV_EN
    assign is_div      = is_rtype & ((funct == 6'h1A) | (funct == 6'h1B));
    assign md_start    = fire & (is_mult | is_div);
`else
    assign md_start    = fire & is_mult;
`endif

    // Signed ops have an even funct; the unit works on magnitudes
    assign md_signed = ~funct[0];
    assign sign_a    = md_signed & op_a[W-1];
    assign sign_b    = md_signed & fwd_b[W-1];
    assign mag_a     = sign_a ? -op_a : op_a;
    assign mag_b     = sign_b ? -fwd_b : fwd_b;

    always_comb begin
        alu_result = '0;
        unique case (id_ex_alu_op)
            2'b00: alu_result = op_a + op_b;
            2'b01: alu_result = op_a - op_b;
            2'b11: alu_result = op_a | op_b;
            2'b10: begin
                case (funct)
                    6'h20, 6'h21: alu_result = op_a + op_b;
                    6'h22, 6'h23: alu_result = op_a - op_b;
                    6'h24:        alu_result = op_a & op_b;
                    6'h25:        alu_result = op_a | op_b;
                    6'h26:        alu_result = op_a ^ op_b;
                    6'h27:        alu_result = ~(op_a | op_b);
                    6'h2A:        alu_result = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    6'h2B:        alu_result = {{(W-1){1'b0}}, op_a < op_b};
                    6'h10:        alu_result = hi_q;
                    6'h12:        alu_result = lo_q;
                    default:      alu_result = '0;
                endcase
            end
        endcase
    end

    assign zero = (alu_result == '0);

    // One shift-add or restoring-subtract step per busy cycle
    always_comb begin
        mul_sum    = md_lo_q[0] ? (md_acc_q + {1'b0, md_b_q}) : md_acc_q;
        step_acc_d = {1'b0, mul_sum[W:1]};
        step_lo_d  = {mul_sum[0], md_lo_q[W-1:1]};
`ifdef EX_MD_DIV_EN
        div_shift  = {md_acc_q[W-1:0], md_lo_q[W-1]};
        div_trial  = div_shift - {1'b0, md_b_q};
        if (md_is_div_q) begin
            if (!div_trial[W]) begin
                step_acc_d = div_trial;
                step_lo_d  = {md_lo_q[W-2:0], 1'b1};
            end else begin
                step_acc_d = div_shift;
                step_lo_d  = {md_lo_q[W-2:0], 1'b0};
            end
        end
`endif
    end

    // Sign-corrected result written to HI/LO on the last step
    always_comb begin
        prod_mag = {step_acc_d[W-1:0], step_lo_d};
        prod_fin = md_neg_q ? -prod_mag : prod_mag;
        fin_hi   = prod_fin[2*W-1:W];
        fin_lo   = prod_fin[W-1:0];
`ifdef EX_MD_DIV_EN
        if (md_is_div_q) begin
            fin_hi = md_neg_rem_q ? -step_acc_d[W-1:0] : step_acc_d[W-1:0];
            fin_lo = md_div0_q ? '1 : (md_neg_q ? -step_lo_d : step_lo_d);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= MD_IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            md_acc_q     <= '0;
            md_lo_q      <= '0;
            md_b_q       <= '0;
            md_neg_q     <= 1'b0;
`ifdef EX_MD_DIV_EN
            md_is_div_q  <= 1'b0;
            md_neg_rem_q <= 1'b0;
            md_div0_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (md_start) begin
                        state_q      <= MD_BUSY;
                        cnt_q        <= CNT_W'(W);
                        md_acc_q     <= '0;
                        md_lo_q      <= mag_a;
                        md_b_q       <= mag_b;
                        md_neg_q     <= sign_a ^ sign_b;
`ifdef EX_MD_DIV_EN
                        md_is_div_q  <= is_div;
                        md_neg_rem_q <= sign_a;
                        md_div0_q    <= (fwd_b == '0);
`endif
                    end
                    if (fire && is_mthi) hi_q <= op_a;
                    if (fire && is_mtlo) lo_q <= op_a;
                end
                MD_BUSY: begin
                    md_acc_q <= step_acc_d;
                    md_lo_q  <= step_lo_d;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= MD_IDLE;
                        hi_q    <= fin_hi;
                        lo_q    <= fin_lo;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_stage_md.sv
// Randomised self-checking bench for ex_stage_md against an arithmetic reference model.
module tb_ex_stage_md;
    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_ex_valid;
    logic [31:0]   id_ex_instr;
    logic [1:0]    id_ex_alu_op;
    logic          id_ex_alu_src;
    logic [W-1:0]  reg1, reg2, id_ex_imm_value, ex_mem_alu_result, mem_wb_write_back_result;
    logic [1:0]    forward_a, forward_b;
    logic [W-1:0]  alu_in2_out, alu_result;
    logic          zero, ex_stall, md_busy;

    ex_stage_md #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .id_ex_valid(id_ex_valid), .id_ex_instr(id_ex_instr),
        .id_ex_alu_op(id_ex_alu_op), .id_ex_alu_src(id_ex_alu_src), .reg1(reg1), .reg2(reg2),
        .id_ex_imm_value(id_ex_imm_value), .ex_mem_alu_result(ex_mem_alu_result),
        .mem_wb_write_back_result(mem_wb_write_back_result), .forward_a(forward_a),
        .forward_b(forward_b), .alu_in2_out(alu_in2_out), .alu_result(alu_result),
        .zero(zero), .ex_stall(ex_stall), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: architectural HI/LO, pending result and remaining busy cycles
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_busy = 0;
    logic         last_stall, last_busy;
    logic [W-1:0] last_res;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] fwd(input logic [1:0] s, input logic [W-1:0] r);
        if (s == 2'b01) return mem_wb_write_back_result;
        if (s == 2'b10) return ex_mem_alu_result;
        return r;
    endfunction

    function automatic logic [W-1:0] model_alu(input logic [1:0] op, input logic [5:0] fn,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return a | b;
        if (fn == 6'h20 || fn == 6'h21) return a + b;
        if (fn == 6'h22 || fn == 6'h23) return a - b;
        if (fn == 6'h24) return a & b;
        if (fn == 6'h25) return a | b;
        if (fn == 6'h26) return a ^ b;
        if (fn == 6'h27) return ~(a | b);
        if (fn == 6'h2A) return (sa < sb) ? 32'd1 : 32'd0;
        if (fn == 6'h2B) return (a < b) ? 32'd1 : 32'd0;
        if (fn == 6'h10) return m_hi;
        if (fn == 6'h12) return m_lo;
        return '0;
    endfunction

    // Start a mult/div in the model: the result appears in HI/LO W cycles later
    task automatic model_md(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] r64;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (fn == 6'h18) begin
            r64 = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
            p_hi = r64[63:32]; p_lo = r64[31:0]; m_busy = W;
        end else if (fn == 6'h19) begin
            r64 = {32'b0, a} * {32'b0, b};
            p_hi = r64[63:32]; p_lo = r64[31:0]; m_busy = W;
        end
`ifdef EX_MD_DIV_EN
        else if (fn == 6'h1A) begin
            if (b == '0) begin p_hi = a; p_lo = '1; end
            else begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
            m_busy = W;
        end else if (fn == 6'h1B) begin
            if (b == '0) begin p_hi = a; p_lo = '1; end
            else begin p_lo = a / b; p_hi = a % b; end
            m_busy = W;
        end
`endif
    endtask

    task automatic cycle();
        logic [W-1:0] a, fb, b, er;
        logic [5:0]   fn;
        logic         hl, es, fire;
        @(negedge clk);
        a  = fwd(forward_a, reg1);
        fb = fwd(forward_b, reg2);
        b  = id_ex_alu_src ? id_ex_imm_value : fb;
        fn = id_ex_instr[5:0];
        hl = id_ex_valid && id_ex_alu_op == 2'b10 &&
             ((fn >= 6'h10 && fn <= 6'h13) || (fn >= 6'h18 && fn <= 6'h1B));
        es = hl && (m_busy > 0);
        er = model_alu(id_ex_alu_op, fn, a, b);
        check("alu_result", alu_result, er);
        check("zero", zero, er == '0);
        check("alu_in2_out", alu_in2_out, fb);
        check("ex_stall", ex_stall, es);
        check("md_busy", md_busy, m_busy > 0);
        last_stall = ex_stall;
        last_busy  = md_busy;
        last_res   = alu_result;
        fire = id_ex_valid && !es;
        @(posedge clk);
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 0;
        end else begin
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; end
            end
            if (fire && id_ex_alu_op == 2'b10) begin
                if (fn == 6'h11) m_hi = a;
                else if (fn == 6'h13) m_lo = a;
                else model_md(fn, a, fb);
            end
        end
        #1;
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        id_ex_valid = 1'b1; id_ex_alu_op = 2'b10; id_ex_instr = {26'h0, fn};
        id_ex_alu_src = 1'b0; forward_a = 2'b00; forward_b = 2'b00;
        reg1 = a; reg2 = b;
    endtask

    // Hold an instruction in EX until it fires, as the pipeline would
    task automatic issue(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        rtype(fn, a, b);
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (!last_stall) return;
        end
        check("issue_timeout", 1, 0);
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 20));
            1:       return -32'($urandom_range(1, 20));
            2:       return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] fns [20];
        int stalls;
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                6'h10, 6'h12, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12};
        id_ex_imm_value = '0; ex_mem_alu_result = '0; mem_wb_write_back_result = '0;
        reset = 1'b1;
        rtype(6'h10, 0, 0);
        #1;
        cycle(); cycle();
        reset = 1'b0;
        cycle();
        check("reset_hi", last_res, 0);
        check("reset_busy", last_busy, 0);
        issue(6'h12, 0, 0);
        check("reset_lo", last_res, 0);

        // Forwarding: EX/MEM on A, register or 11-code on B
        id_ex_alu_op = 2'b00; forward_a = 2'b10; ex_mem_alu_result = 5; reg1 = 99; reg2 = 7;
        forward_b = 2'b00;
        cycle();
        check("fwd_add_b00", last_res, 12);
        forward_b = 2'b11;
        cycle();
        check("fwd_add_b11", last_res, 12);

        // Signed multiply followed by dependent mfhi/mflo
        issue(6'h18, -32'd3, 32'd7);
        rtype(6'h10, 0, 0);
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (!last_stall) break;
            stalls++;
        end
        check("mult_stall_cycles", stalls, W);
        check("mult_hi", last_res, 32'hFFFF_FFFF);
        issue(6'h12, 0, 0);
        check("mult_lo", last_res, 32'hFFFF_FFEB);

`ifdef EX_MD_DIV_EN
        issue(6'h1A, -32'd7, 32'd2);
        issue(6'h10, 0, 0); check("div_hi", last_res, 32'hFFFF_FFFF);
        issue(6'h12, 0, 0); check("div_lo", last_res, 32'hFFFF_FFFD);
        issue(6'h1B, 32'd7, 32'd0);
        issue(6'h10, 0, 0); check("divu0_hi", last_res, 32'd7);
        issue(6'h12, 0, 0); check("divu0_lo", last_res, 32'hFFFF_FFFF);
        issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(6'h12, 0, 0); check("divmin_lo", last_res, 32'h8000_0000);
        issue(6'h10, 0, 0); check("divmin_hi", last_res, 0);
`else
        issue(6'h11, 32'hAAAA, 0);
        issue(6'h13, 32'h5555, 0);
        issue(6'h1A, 32'd9, 32'd3);
        cycle();
        check("nodiv_busy", last_busy, 0);
        issue(6'h10, 0, 0); check("nodiv_hi", last_res, 32'hAAAA);
        issue(6'h12, 0, 0); check("nodiv_lo", last_res, 32'h5555);
        issue(6'h18, 32'd2, 32'd3);
        rtype(6'h1B, 32'd9, 32'd3);
        cycle();
        check("nodiv_stalls_on_mult", last_stall, 1);
        issue(6'h1B, 32'd9, 32'd3);
`endif

        // Independent add runs alongside BUSY; mtlo waits and then wins over the product
        issue(6'h18, 32'd5, 32'd6);
        id_ex_alu_op = 2'b00; reg1 = 40; reg2 = 2;
        cycle();
        check("add_no_stall", last_stall, 0);
        check("add_during_busy", last_res, 42);
        rtype(6'h13, 32'h1234, 0);
        cycle();
        check("mtlo_stalls", last_stall, 1);
        issue(6'h13, 32'h1234, 0);
        issue(6'h12, 0, 0); check("mtlo_wins", last_res, 32'h1234);
        issue(6'h10, 0, 0); check("mult_small_hi", last_res, 0);

        // Reset during BUSY aborts the operation
        issue(6'h18, -32'd5, 32'h1234_5678);
        id_ex_alu_op = 2'b00;
        for (int i = 0; i < 9; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("abort_busy", last_busy, 0);
        issue(6'h10, 0, 0); check("abort_hi", last_res, 0);
        issue(6'h12, 0, 0); check("abort_lo", last_res, 0);

        // Bubble with a mult funct must not start the unit
        rtype(6'h18, 32'd3, 32'd3);
        id_ex_valid = 1'b0;
        cycle();
        id_ex_valid = 1'b1; id_ex_alu_op = 2'b00;
        cycle();
        check("bubble_no_start", last_busy, 0);

        for (int i = 0; i < 3000; i++) begin
            if (!(last_stall && $urandom_range(0, 3) != 0)) begin
                id_ex_valid   = ($urandom_range(0, 9) != 0);
                id_ex_alu_op  = 2'($urandom_range(0, 3));
                id_ex_instr   = $urandom;
                if ($urandom_range(0, 9) != 0) id_ex_instr[5:0] = fns[$urandom_range(0, 19)];
                id_ex_alu_src = 1'($urandom_range(0, 1));
                forward_a     = 2'($urandom_range(0, 3));
                forward_b     = 2'($urandom_range(0, 3));
                reg1 = rand_val(); reg2 = rand_val(); id_ex_imm_value = rand_val();
                ex_mem_alu_result = rand_val(); mem_wb_write_back_result = rand_val();
            end
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
